// File: rtl/div_arbiter.sv
// div_arbiter
//   Shares one sequential divider (div_fsm) between two requesters.
//   Requests are granted round-robin from IDLE, the operands are held for the
//   divider, and the result is returned on a shared result bus with a
//   one-cycle resp_valid pulse to the owning requester. A zero divisor is
//   answered directly (quotient all ones, remainder = dividend, resp_err = 1).
//   renew aborts any operation in flight and refreshes the divider.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   renew                  abort/refresh strobe
//   req_valid/req_ready    per-requester handshake (2 bits each)
//   req{0,1}_dividend/_divisor  requester operands
//   resp_valid             per-requester result pulse
//   quotient, remainder, resp_err  shared result bus (held until next result)
//   busy                   high whenever the arbiter is not idle
//   div_en, div_renew, div_dividend, div_divisor   divider command side
//   div_ready, div_vld_out, div_quotient, div_remainder  divider status side
//
// Build option
//   DIV_TIMEOUT_EN  adds a watchdog: after TIMEOUT_CYCLES in ISSUE/WAIT the
//                   divider is renewed and an error result (0/0) is returned.

module div_arbiter #(
  parameter int DATAWIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 4 * DATAWIDTH + 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 renew,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [DATAWIDTH-1:0] req0_dividend,
  input  logic [DATAWIDTH-1:0] req0_divisor,
  input  logic [DATAWIDTH-1:0] req1_dividend,
  input  logic [DATAWIDTH-1:0] req1_divisor,
  output logic [1:0]           resp_valid,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 div_en,
  output logic                 div_renew,
  output logic [DATAWIDTH-1:0] div_dividend,
  output logic [DATAWIDTH-1:0] div_divisor,
  input  logic                 div_ready,
  input  logic                 div_vld_out,
  input  logic [DATAWIDTH-1:0] div_quotient,
  input  logic [DATAWIDTH-1:0] div_remainder
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 rr_last;      // index of the requester served last
  logic                 grant_idx;
  logic                 accept;
  logic                 timeout_hit;
  logic [DATAWIDTH-1:0] sel_dividend;
  logic [DATAWIDTH-1:0] sel_divisor;
  logic [DATAWIDTH-1:0] dividend_p0;
  logic [DATAWIDTH-1:0] divisor_p0;
  logic                 grant_p0;

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    grant_idx = req_valid[1];
    if (req_valid == 2'b11) begin
      grant_idx = ~rr_last;
    end
  end

  assign accept       = (state == IDLE) && !rst && !renew && (req_valid != 2'b00);
  assign sel_dividend = grant_idx ? req1_dividend : req0_dividend;
  assign sel_divisor  = grant_idx ? req1_divisor  : req0_divisor;

  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (sel_divisor == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (timeout_hit) begin
          state_nxt = RESP;
        end else if (div_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (timeout_hit) begin
          state_nxt = RESP;
        end else if (div_vld_out) begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (renew) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      grant_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_last  <= grant_idx;
        grant_p0 <= grant_idx;
      end
    end
  end

  // Stage p0: operands latched at accept, held for the divider.
  always_ff @(posedge clk) begin
    if (accept) begin
      dividend_p0 <= sel_dividend;
      divisor_p0  <= sel_divisor;
    end
  end

  assign div_dividend = dividend_p0;
  assign div_divisor  = divisor_p0;

  // Result stage: the divider output is only valid the cycle after
  // div_vld_out, which is why it is sampled in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      resp_err  <= 1'b0;
    end else if (!renew) begin
      if (accept && (sel_divisor == '0)) begin
        quotient  <= '1;
        remainder <= sel_dividend;
        resp_err  <= 1'b1;
      end else if (state == CAPTURE) begin
        quotient  <= div_quotient;
        remainder <= div_remainder;
        resp_err  <= 1'b0;
      end else if (timeout_hit) begin
        quotient  <= '0;
        remainder <= '0;
        resp_err  <= 1'b1;
      end
    end
  end

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  // to_cnt counts completed ISSUE/WAIT cycles; the limit is reached on
  // the TIMEOUT_CYCLES-th such cycle.
  always_ff @(posedge clk) begin
    if (rst || renew) begin
      to_cnt <= '0;
    end else if ((state == ISSUE || state == WAIT) && !timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign timeout_hit = !rst && !renew && (state == ISSUE || state == WAIT)
                       && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;

  // The watchdog limit only matters when the watchdog is built in.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_limit_unused
  end
`endif

  always_comb begin
    resp_valid = 2'b00;
    if (!rst && !renew && (state == RESP)) begin
      resp_valid[grant_p0] = 1'b1;
    end
  end

  assign busy      = !rst && (state != IDLE);
  assign div_en    = !rst && !renew && (state == ISSUE);
  assign div_renew = rst || renew || timeout_hit;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
//   Directed bench for div_arbiter with a behavioural stand-in for the shared
//   sequential divider. The stand-in presents garbage on its result bus while
//   div_vld_out is high and the true result on the following cycle.

module tb_div_arbiter;

  localparam int DW  = 8;
  localparam int LAT = 8;

  logic          clk;
  logic          rst;
  logic          renew;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
  logic [1:0]    resp_valid;
  logic [DW-1:0] quotient, remainder;
  logic          resp_err, busy, div_en, div_renew;
  logic [DW-1:0] div_dividend, div_divisor;
  logic          div_ready, div_vld_out;
  logic [DW-1:0] div_quotient, div_remainder;

  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;
  int overlap_cnt = 0;
  int den_cnt  = 0;
  int lat, vlat, rc, c0, n;
  logic en1;

  div_arbiter #(.DATAWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .renew(renew),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
    .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
    .resp_valid(resp_valid), .quotient(quotient), .remainder(remainder),
    .resp_err(resp_err), .busy(busy),
    .div_en(div_en), .div_renew(div_renew),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_vld_out(div_vld_out),
    .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Divider stand-in
  logic [DW-1:0] m_a, m_b;
  int            m_cnt;
  int            m_st;
  logic          stall;

  initial begin
    div_ready = 1'b1; div_vld_out = 1'b0; m_st = 0; m_cnt = 0;
    div_quotient = '0; div_remainder = '0; m_a = '0; m_b = 8'd1;
  end

  always @(posedge clk) begin
    if (div_renew) begin
      m_st <= 0; div_ready <= 1'b1; div_vld_out <= 1'b0;
    end else begin
      case (m_st)
        0: if (div_en && div_ready) begin
          m_a <= div_dividend; m_b <= div_divisor; m_cnt <= LAT;
          div_ready <= 1'b0; div_quotient <= 8'h5A; div_remainder <= 8'hA5;
          m_st <= 1;
        end
        1: if (!stall) begin
          if (m_cnt == 0) begin
            div_vld_out <= 1'b1; m_st <= 2;
          end else begin
            m_cnt <= m_cnt - 1;
          end
        end
        2: begin
          div_vld_out <= 1'b0; div_quotient <= m_a / m_b;
          div_remainder <= m_a % m_b; div_ready <= 1'b1; m_st <= 0;
        end
        default: m_st <= 0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (resp_valid != 2'b00) resp_cnt <= resp_cnt + 1;
    if (resp_valid == 2'b11) overlap_cnt <= overlap_cnt + 1;
    if (div_en) den_cnt <= den_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called right after an accept has been set up; returns at the IDLE cycle
  // following the response pulse.
  task automatic wait_resp(input string tag, input logic [1:0] ev,
                           input logic [7:0] eq, input logic [7:0] er, input logic eerr,
                           output int o_lat, output int o_vlat, output logic o_en1);
    int k;
    int vat;
    k = 1; vat = -1;
    @(negedge clk);
    req_valid = req_valid & ~ev;
    o_en1 = div_en;
    if (div_vld_out) vat = k;
    while (resp_valid == 2'b00 && k < 300) begin
      @(negedge clk);
      k++;
      if (div_vld_out) vat = k;
    end
    chk({tag, "_valid"}, resp_valid, ev);
    chk({tag, "_quot"},  quotient,  eq);
    chk({tag, "_rem"},   remainder, er);
    chk({tag, "_err"},   resp_err,  eerr);
    o_lat  = k;
    o_vlat = (vat < 0) ? -1 : k - vat;
    @(negedge clk);
    chk({tag, "_pulse"}, resp_valid, 2'b00);
  endtask

  task automatic run_one(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic eerr);
    logic [1:0] m;
    int   l, vl;
    logic e1;
    m = (idx == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if (idx == 1) begin
      req1_dividend = a; req1_divisor = b;
    end else begin
      req0_dividend = a; req0_divisor = b;
    end
    req_valid = m;
    #1;
    chk({tag, "_ready"}, req_ready, m);
    wait_resp(tag, m, eq, er, eerr, l, vl, e1);
    if (b == 8'd0) begin
      chk({tag, "_lat0"}, l, 1);
    end else begin
      chk({tag, "_issue"}, e1, 1'b1);
      chk({tag, "_vlat"}, vl, 2);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; renew = 1'b0; req_valid = 2'b00; stall = 1'b0;
    req0_dividend = '0; req0_divisor = '0; req1_dividend = '0; req1_divisor = '0;

    // Reset values
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_resp",  resp_valid, 2'b00);
    chk("rst_quot",  quotient, 8'h00);
    chk("rst_rem",   remainder, 8'h00);
    chk("rst_err",   resp_err, 1'b0);
    chk("rst_busy",  busy, 1'b0);
    chk("rst_en",    div_en, 1'b0);
    chk("rst_renew", div_renew, 1'b1);
    @(negedge clk);
    rst = 1'b0; req_valid = 2'b00;

    // Single request 100/7
    run_one("r029", 0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

    // Tie after reset: requester 0 first, then requester 1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    req0_dividend = 8'd200; req0_divisor = 8'd3;
    req1_dividend = 8'd255; req1_divisor = 8'd16;
    req_valid = 2'b11;
    #1;
    chk("r030_tie", req_ready, 2'b01);
    wait_resp("r030_a", 2'b01, 8'd66, 8'd2, 1'b0, lat, vlat, en1);
    chk("r030_next_ready", req_ready, 2'b10);
    wait_resp("r030_b", 2'b10, 8'd15, 8'd15, 1'b0, lat, vlat, en1);
    chk("r030_b_vlat", vlat, 2);

    // Divide by zero on requester 1
    c0 = den_cnt;
    run_one("r031", 1, 8'd37, 8'd0, 8'hFF, 8'd37, 1'b1);
    chk("r031_no_en", den_cnt, c0);

    // Abort with renew three cycles into WAIT
    @(negedge clk);
    req0_dividend = 8'd200; req0_divisor = 8'd3; req_valid = 2'b01;
    #1;
    chk("r032_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    chk("r032_issue", div_en, 1'b1);
    repeat (4) @(negedge clk);
    chk("r032_busy", busy, 1'b1);
    chk("r032_hold_dvd", div_dividend, 8'd200);
    renew = 1'b1; req_valid = 2'b10;
    #1;
    chk("r032_div_renew", div_renew, 1'b1);
    chk("r032_ready_blk", req_ready, 2'b00);
    chk("r032_resp_blk", resp_valid, 2'b00);
    rc = resp_cnt;
    @(negedge clk);
    renew = 1'b0; req_valid = 2'b00;
    chk("r032_idle", busy, 1'b0);
    repeat (20) @(negedge clk);
    chk("r032_no_resp", resp_cnt, rc);
    run_one("r032_next", 0, 8'd9, 8'd2, 8'd4, 8'd1, 1'b0);

    // Reset mid-WAIT
    @(negedge clk);
    req0_dividend = 8'd200; req0_divisor = 8'd3; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("r034_busy", busy, 1'b1);
    rst = 1'b1; req_valid = 2'b11;
    req0_dividend = 8'd50; req0_divisor = 8'd5;
    req1_dividend = 8'd60; req1_divisor = 8'd7;
    #1;
    chk("r034_ready", req_ready, 2'b00);
    chk("r034_busy0", busy, 1'b0);
    chk("r034_en", div_en, 1'b0);
    chk("r034_div_renew", div_renew, 1'b1);
    @(negedge clk);
    chk("r034_quot", quotient, 8'h00);
    chk("r034_rem", remainder, 8'h00);
    chk("r034_err", resp_err, 1'b0);
    chk("r034_resp", resp_valid, 2'b00);
    rst = 1'b0;
    #1;
    chk("r034_tie", req_ready, 2'b01);
    wait_resp("r034_a", 2'b01, 8'd10, 8'd0, 1'b0, lat, vlat, en1);
    chk("r034_next_ready", req_ready, 2'b10);
    wait_resp("r034_b", 2'b10, 8'd8, 8'd4, 1'b0, lat, vlat, en1);

    // Operand boundaries
    run_one("b_max",  1, 8'd255, 8'd1,   8'd255, 8'd0, 1'b0);
    run_one("b_zdvd", 0, 8'd0,   8'd5,   8'd0,   8'd0, 1'b0);
    run_one("b_small",1, 8'd5,   8'd200, 8'd0,   8'd5, 1'b0);
    run_one("b_zz",   0, 8'd0,   8'd0,   8'hFF,  8'd0, 1'b1);

`ifdef DIV_TIMEOUT_EN
    // Divider that never answers
    stall = 1'b1;
    @(negedge clk);
    req0_dividend = 8'd7; req0_divisor = 8'd3; req_valid = 2'b01;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      req_valid = 2'b00;
    end while (!div_renew && n < 200);
    chk("r033_to_cycle", n, 40);
    @(negedge clk);
    chk("r033_valid", resp_valid, 2'b01);
    chk("r033_quot", quotient, 8'h00);
    chk("r033_rem", remainder, 8'h00);
    chk("r033_err", resp_err, 1'b1);
    stall = 1'b0;
`endif

    chk("no_overlap", overlap_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8: operand/result width, matching the shared div_fsm divider.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4*DATAWIDTH+8: watchdog limit in cycles, used only under REQ-024.
REQ-003 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port renew  input  1: measurement refresh; aborts any operation in flight.
REQ-006 SHALL have port req_valid  input  2: per-requester request strobe.
REQ-007 SHALL have port req_ready  output  2: per-requester accept.
REQ-008 SHALL have ports req0_dividend, req0_divisor, req1_dividend, req1_divisor  input  DATAWIDTH each: requester operands.
REQ-009 SHALL have port resp_valid  output  2: one-cycle result pulse to the owning requester.
REQ-010 SHALL have ports quotient, remainder  output  DATAWIDTH each, and resp_err  output  1: shared result bus.
REQ-011 SHALL have port busy  output  1: high in every state except IDLE.
REQ-012 SHALL have divider-side ports div_en, div_renew (output 1), div_dividend, div_divisor (output DATAWIDTH), div_ready, div_vld_out (input 1), div_quotient, div_remainder (input DATAWIDTH).

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, CAPTURE, RESP.
REQ-014 In IDLE with any req_valid set, SHALL grant round-robin, with the requester not served last winning a tie, and SHALL assert req_ready for the granted requester only, in that same cycle (combinational).
REQ-015 On accept, SHALL register the operands and grant index; div_dividend/div_divisor SHALL be driven from these registers and held stable until the next accept.
REQ-016 If the accepted divisor is 0, SHALL go IDLE->RESP without using the divider: quotient=all ones, remainder=dividend, resp_err=1.
REQ-017 Otherwise SHALL go to ISSUE and assert div_en; when div_ready=1 it SHALL move to WAIT on the next edge, and div_en SHALL be low in every other state.
REQ-018 In WAIT, SHALL move to CAPTURE on div_vld_out=1.
REQ-019 In CAPTURE, SHALL register div_quotient/div_remainder, because the divider result is valid only on the cycle after div_vld_out, then move to RESP.
REQ-020 In RESP, SHALL pulse resp_valid[grant] for one cycle, then return to IDLE; quotient/remainder/resp_err SHALL hold until the next RESP.
REQ-021 Overhead SHALL be: accept->ISSUE 1 cycle; div_vld_out->resp_valid 2 cycles; divide-by-zero accept->resp_valid 1 cycle.
REQ-022 renew=1 in any state SHALL force IDLE next cycle, drive div_renew=1 that cycle, and issue no resp_valid for the aborted request; req_ready SHALL be 0 while renew=1.
REQ-023 A requester SHALL NOT be accepted twice without an intervening RESP or abort, and the other requester's pending req_valid SHALL be served on the first IDLE cycle after RESP.

Configuration
REQ-024 With DIV_TIMEOUT_EN defined: a cycle counter SHALL run in ISSUE/WAIT, and on reaching TIMEOUT_CYCLES SHALL pulse div_renew for 1 cycle, then enter RESP with quotient=0, remainder=0, resp_err=1.
REQ-025 Without DIV_TIMEOUT_EN: no counter; div_renew SHALL be driven only by renew/rst, and resp_err SHALL be set only by divide-by-zero.

Reset
REQ-026 While rst=1, SHALL hold state=IDLE, req_ready=0, resp_valid=0, quotient=0, remainder=0, resp_err=0, busy=0, div_en=0, and div_renew=1.
REQ-027 Reset SHALL set the round-robin pointer to "requester 1 served last", so requester 0 wins the first tie.
REQ-028 rst SHALL take priority over renew and over every state transition, including mid-operation.

Verification (DATAWIDTH=8, real div_fsm attached)
REQ-029 req0 100/7 -> single req_ready[0]; resp_valid[0] with quotient=14, remainder=2, resp_err=0.
REQ-030 req0 and req1 both valid after reset (200/3, 255/16) -> req0 served first (66 r2), then req1 (15 r15); no overlapping resp_valid.
REQ-031 req1 37/0 -> resp_valid[1] exactly 1 cycle after accept, quotient=0xFF, remainder=37, resp_err=1; div_en never asserted.
REQ-032 renew pulsed 3 cycles into WAIT for 200/3 -> div_renew=1 that cycle, no resp_valid, then next request 9/2 returns 4 r1.
REQ-033 DIV_TIMEOUT_EN defined, divider stub never raising div_vld_out -> div_renew pulse at TIMEOUT_CYCLES=40, then resp_valid with 0/0 and resp_err=1.
REQ-034 rst asserted mid-WAIT -> all outputs at reset values next cycle, div_renew=1, and tie behaviour restarts at requester 0.
